// File: rtl/gb_joypad_p1_reg_pkg.sv
// Shared constants and types for the JOYP/P1 register at FF00.
// Optional column debounce is selected with JOYPAD_DEBOUNCE_EN.
package gb_joypad_pkg;

    localparam logic [15:0] JOYP_ADDR      = 16'hFF00;
    localparam logic [1:0]  JOYP_SEL_RESET = 2'b11;
    localparam logic [1:0]  JOYP_UNUSED    = 2'b11;
    localparam int          IF_JOYPAD_BIT  = 4;

    typedef logic [3:0] joyp_nib_t;

    // With both rows deselected the column lines float high.
    function automatic joyp_nib_t joyp_effective_nib(input logic [1:0] sel, input joyp_nib_t filt);
        return (sel == JOYP_SEL_RESET) ? 4'hF : filt;
    endfunction

endpackage

// File: rtl/gb_joypad_p1_reg_if.sv
// CPU bus slice seen by the JOYP register: address, strobes, write data and registered read data.
// valid/ready: cpu_wr and cpu_rd are single-cycle strobes, always accepted; cpu_rdata is valid one cycle after cpu_rd.
interface gb_joypad_p1_reg_if;
    logic [15:0] cpu_addr;
    logic        cpu_wr;
    logic        cpu_rd;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;

    modport master (output cpu_addr, output cpu_wr, output cpu_rd, output cpu_wdata, input cpu_rdata);
    modport slave  (input cpu_addr, input cpu_wr, input cpu_rd, input cpu_wdata, output cpu_rdata);
endinterface

// File: rtl/gb_joypad_p1_reg_input_filter.sv
// Four-lane column synchronizer with an optional per-lane debounce counter (JOYPAD_DEBOUNCE_EN).
module gb_joypad_input_filter
    import gb_joypad_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic      clk,
    input  logic      reset,
    input  joyp_nib_t raw,
    output joyp_nib_t filt
);

    joyp_nib_t sync_q [SYNC_STAGES];
    joyp_nib_t synced;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 4'hF;
        end else begin
            sync_q[0] <= raw;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

`ifdef JOYPAD_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt_q [4];
    logic [CW-1:0] cnt_d [4];
    joyp_nib_t     filt_q, filt_d;

    // A lane only follows the synced value after it has differed for DEBOUNCE_CYCLES samples in a row.
    always_comb begin
        filt_d = filt_q;
        for (int b = 0; b < 4; b++) begin
            cnt_d[b] = '0;
            if (synced[b] != filt_q[b]) begin
                if (cnt_q[b] == CNT_LAST) filt_d[b] = synced[b];
                else                      cnt_d[b] = cnt_q[b] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            filt_q <= 4'hF;
            for (int b = 0; b < 4; b++) cnt_q[b] <= '0;
        end else begin
            filt_q <= filt_d;
            for (int b = 0; b < 4; b++) cnt_q[b] <= cnt_d[b];
        end
    end

    assign filt = filt_q;
`else
    assign filt = synced;
`endif

endmodule

// File: rtl/gb_joypad_p1_reg.sv
// JOYP/P1 register: row-select flops, registered FF00 read mux and falling-edge joypad interrupt.
// Column debounce is enabled by defining JOYPAD_DEBOUNCE_EN.
module gb_joypad_p1_reg
    import gb_joypad_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset,
    gb_joypad_p1_reg_if.slave   bus,
    input  logic                P10,
    input  logic                P11,
    input  logic                P12,
    input  logic                P13,
    output logic                P14,
    output logic                P15,
    output logic                irq_joypad
);

    logic [1:0] sel_q, sel_d;
    joyp_nib_t  prev_q, filt, nib;
    logic [7:0] rdata_q, rdata_d;
    logic       irq_q, irq_d;
    logic       wr_hit, rd_hit;

    gb_joypad_input_filter #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_filter (
        .clk   (clk),
        .reset (reset),
        .raw   ({P13, P12, P11, P10}),
        .filt  (filt)
    );

    assign wr_hit = bus.cpu_wr && (bus.cpu_addr == JOYP_ADDR);
    assign rd_hit = bus.cpu_rd && (bus.cpu_addr == JOYP_ADDR);
    assign nib    = joyp_effective_nib(sel_q, filt);

    // Reads see pre-write sel/nib because both come from the current flop values.
    always_comb begin
        sel_d   = wr_hit ? bus.cpu_wdata[5:4] : sel_q;
        rdata_d = rd_hit ? {JOYP_UNUSED, sel_q, nib} : 8'hFF;
        irq_d   = |(prev_q & ~nib);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q   <= JOYP_SEL_RESET;
            prev_q  <= 4'hF;
            rdata_q <= 8'hFF;
            irq_q   <= 1'b0;
        end else begin
            sel_q   <= sel_d;
            prev_q  <= nib;
            rdata_q <= rdata_d;
            irq_q   <= irq_d;
        end
    end

    assign P14           = sel_q[0];
    assign P15           = sel_q[1];
    assign bus.cpu_rdata = rdata_q;
    assign irq_joypad    = irq_q;

endmodule

// File: tb/tb_gb_joypad_p1_reg.sv
// Self-checking bench for gb_joypad_p1_reg: directed scenarios plus randomized traffic against a pin-history model.
module tb_gb_joypad_p1_reg;
    localparam int S = 2;
    localparam int D = 4;
`ifdef JOYPAD_DEBOUNCE_EN
    localparam int SETTLE = S + D + 4;
`else
    localparam int SETTLE = S + 4;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] pins = 4'hF;
    logic       p14, p15, irq;

    always #5 clk = ~clk;

    gb_joypad_p1_reg_if bus ();

    gb_joypad_p1_reg #(.SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus.slave),
        .P10        (pins[0]),
        .P11        (pins[1]),
        .P12        (pins[2]),
        .P13        (pins[3]),
        .P14        (p14),
        .P15        (p15),
        .irq_joypad (irq)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int irq_cnt  = 0;

    // Reference state: last pin values sampled at each edge (index 0 = newest), row select, filtered columns.
    logic [3:0] p_hist [32];
    logic [1:0] sel_m;
    logic [3:0] filt_m, nib_p, nib_pp;
    logic [7:0] exp_rdata;
    logic       exp_irq;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rst, input logic wr, input logic rd, input logic [15:0] addr,
                        input logic [7:0] wd, input logic [3:0] pv);
        logic [1:0] sel_before;
        logic [3:0] nib_before;
        logic       all_diff;
        reset         = rst;
        bus.cpu_wr    = wr;
        bus.cpu_rd    = rd;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wd;
        pins          = pv;
        @(posedge clk);
        sel_before = sel_m;
        nib_before = nib_p;
        if (rst) begin
            for (int i = 0; i < 32; i++) p_hist[i] = 4'hF;
            sel_m     = 2'b11;
            filt_m    = 4'hF;
            exp_rdata = 8'hFF;
            exp_irq   = 1'b0;
            nib_p     = 4'hF;
            nib_pp    = 4'hF;
        end else begin
            for (int i = 31; i > 0; i--) p_hist[i] = p_hist[i-1];
            p_hist[0] = pv;
            if (wr && addr == 16'hFF00) sel_m = wd[5:4];
`ifdef JOYPAD_DEBOUNCE_EN
            // A column follows the pin only once its synchronized value disagreed for D samples running.
            for (int b = 0; b < 4; b++) begin
                all_diff = 1'b1;
                for (int j = 0; j < D; j++)
                    if (p_hist[S+j][b] == filt_m[b]) all_diff = 1'b0;
                if (all_diff) filt_m[b] = ~filt_m[b];
            end
`else
            all_diff = 1'b0;
            filt_m   = p_hist[S-1];
`endif
            exp_rdata = (rd && addr == 16'hFF00) ? {2'b11, sel_before, nib_before} : 8'hFF;
            exp_irq   = |(nib_pp & ~nib_p);
            nib_pp    = nib_p;
            nib_p     = (sel_m == 2'b11) ? 4'hF : filt_m;
        end
        #1;
        chk("rdata", bus.cpu_rdata, exp_rdata);
        chk("irq", {7'd0, irq}, {7'd0, exp_irq});
        chk("p14", {7'd0, p14}, {7'd0, sel_m[0]});
        chk("p15", {7'd0, p15}, {7'd0, sel_m[1]});
        if (irq === 1'b1) irq_cnt++;
    endtask

    task automatic idle(input int n, input logic [3:0] pv);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, pv);
    endtask

    initial begin
        int base;
        logic        r_rst, r_wr, r_rd;
        logic [15:0] r_addr;
        logic [7:0]  r_wd;
        logic [3:0]  r_pins;
        bus.cpu_wr = 1'b0; bus.cpu_rd = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;

        // 1: reset, read FF00
        step(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 4'hF);
        step(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 4'hF);
        base = irq_cnt;
        step(1'b0, 1'b0, 1'b1, 16'hFF00, 8'h00, 4'hF);
        chk("t1_read", bus.cpu_rdata, 8'hFF);
        chk("t1_rows", {6'd0, p15, p14}, 8'h03);
        idle(3, 4'hF);

        // 2: select directions, press right
        step(1'b0, 1'b1, 1'b0, 16'hFF00, 8'h20, 4'hF);
        chk("t2_rows", {6'd0, p15, p14}, 8'h02);
        idle(SETTLE, 4'hE);
        step(1'b0, 1'b0, 1'b1, 16'hFF00, 8'h00, 4'hE);
        chk("t2_read", bus.cpu_rdata, 8'hEE);
        chk("t2_irqs", 8'(irq_cnt - base), 8'd1);

        // 3: select change exposing a held column fires, deselect does not
        step(1'b0, 1'b1, 1'b0, 16'hFF00, 8'h30, 4'hF);
        idle(SETTLE, 4'hB);
        base = irq_cnt;
        step(1'b0, 1'b1, 1'b0, 16'hFF00, 8'h10, 4'hB);
        chk("t3_rows", {6'd0, p15, p14}, 8'h01);
        idle(3, 4'hB);
        step(1'b0, 1'b0, 1'b1, 16'hFF00, 8'h00, 4'hB);
        chk("t3_read", bus.cpu_rdata, 8'hDB);
        chk("t3_irqs", 8'(irq_cnt - base), 8'd1);
        base = irq_cnt;
        step(1'b0, 1'b1, 1'b0, 16'hFF00, 8'h30, 4'hB);
        idle(3, 4'hB);
        step(1'b0, 1'b0, 1'b1, 16'hFF00, 8'h00, 4'hB);
        chk("t3_read_off", bus.cpu_rdata, 8'hFF);
        chk("t3_irqs_off", 8'(irq_cnt - base), 8'd0);

        // 4: other address ignored; same-cycle write+read returns old value
        idle(SETTLE, 4'hF);
        step(1'b0, 1'b1, 1'b0, 16'hFF01, 8'h00, 4'hF);
        step(1'b0, 1'b0, 1'b1, 16'hFF01, 8'h00, 4'hF);
        chk("t4_read_ff01", bus.cpu_rdata, 8'hFF);
        chk("t4_rows", {6'd0, p15, p14}, 8'h03);
        step(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 4'hF);
        step(1'b0, 1'b1, 1'b1, 16'hFF00, 8'h20, 4'hF);
        chk("t4_wr_rd", bus.cpu_rdata, 8'hFF);
        step(1'b0, 1'b0, 1'b1, 16'hFF00, 8'h00, 4'hF);
        chk("t4_next_rd", bus.cpu_rdata, 8'hEF);

`ifdef JOYPAD_DEBOUNCE_EN
        // 5: glitch filtering on P11 with directions selected
        idle(SETTLE, 4'hF);
        base = irq_cnt;
        idle(3, 4'hD);
        idle(SETTLE, 4'hF);
        step(1'b0, 1'b0, 1'b1, 16'hFF00, 8'h00, 4'hF);
        chk("t5_glitch_read", bus.cpu_rdata, 8'hEF);
        chk("t5_glitch_irqs", 8'(irq_cnt - base), 8'd0);
        idle(7, 4'hD);
        step(1'b0, 1'b0, 1'b1, 16'hFF00, 8'h00, 4'hD);
        chk("t5_long_read", bus.cpu_rdata, 8'hED);
        chk("t5_long_irqs", 8'(irq_cnt - base), 8'd1);
        idle(SETTLE, 4'hF);
`endif

        // 6: reset while P10 held low with directions selected
        step(1'b0, 1'b1, 1'b0, 16'hFF00, 8'h20, 4'hE);
        idle(SETTLE, 4'hE);
        step(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 4'hE);
        base = irq_cnt;
        step(1'b0, 1'b0, 1'b1, 16'hFF00, 8'h00, 4'hE);
        chk("t6_read", bus.cpu_rdata, 8'hFF);
        chk("t6_rows", {6'd0, p15, p14}, 8'h03);
        idle(5, 4'hE);
        idle(4, 4'hF);
        chk("t6_irqs", 8'(irq_cnt - base), 8'd0);

        // Randomized traffic
        r_pins = 4'hF;
        for (int i = 0; i < 1500; i++) begin
            r_rst = ($urandom_range(0, 149) == 0);
            r_wr  = ($urandom_range(0, 3) == 0);
            r_rd  = ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 3))
                0, 1:    r_addr = 16'hFF00;
                2:       r_addr = 16'hFF01;
                default: r_addr = 16'($urandom);
            endcase
            r_wd = 8'($urandom);
            if ($urandom_range(0, 4) == 0) r_pins = 4'($urandom);
            step(r_rst, r_wr, r_rd, r_addr, r_wd, r_pins);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
